// File: rtl/m1_checker.sv
// m1_checker: receive-side verifier for the M1 telemetry word stream.
// Recovers the slot-2 (A), slot-34 (B) and mod-4 (C) counters, checks fill
// slots and pointer continuity, and runs a SEARCH/LOCKED frame-lock FSM.
module m1_checker #(
  parameter int unsigned LOCK_FRAMES   = 2,
  parameter int unsigned UNLOCK_FRAMES = 4,
  parameter logic [11:0] FILL_WORD     = 12'h002
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wordValid,
  input  logic [6:0]  wordPtr,
  input  logic [4:0]  grpNum,
  input  logic [11:0] rxWord,
  input  logic        clrCnt,
  output logic        locked,
  output logic        frameDone,
  output logic        frameOk,
  output logic        errStrobe,
  output logic [4:0]  errMask,
  output logic [15:0] errCount,
  output logic [9:0]  valA,
  output logic [9:0]  valB,
  output logic [7:0]  valC
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_FRAMES);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state, state_nx;
  logic [3:0] goodCnt, badCnt, goodNx, badNx;
  logic       enterSearch;
  logic       seedA, seedB, seedC;
  logic       ptrSeen;      // a previous pointer exists to compare against
  logic [6:0] prevPtr;
  logic       prevBg0;      // previous B word arrived in group 0
  logic       frameBad;     // error seen since last frameDone

  logic       isA, isB, isC, isF, lastSlot;
  logic [9:0] payAB;
  logic [7:0] payC;
  logic       fmtAB, fmtC;
  logic [4:0] mask;
  logic       wordErr, frameErr;

  assign locked = (state == LOCKED);

  // Slot decode and per-word checks against the stored previous values
  always_comb begin
    isA      = (wordPtr == 7'd2);
    isB      = (wordPtr == 7'd34);
    isC      = (wordPtr[1:0] == 2'b01);
    isF      = !(isA || isB || isC);
    lastSlot = (wordPtr == 7'd127);
    payAB    = rxWord[10:1];
    payC     = rxWord[10:3];
    fmtAB    = rxWord[11] | rxWord[0];
    fmtC     = rxWord[11] | (|rxWord[2:0]);
    mask     = '0;
    mask[0]  = isA && (fmtAB || (seedA && payAB != 10'(valA + 10'd1)));
    mask[1]  = isB && (fmtAB || (seedB && payAB != 10'(valB + {9'd0, prevBg0})));
    mask[2]  = isC && (fmtC  || (seedC && payC  != 8'(valC + 8'd1)));
    mask[3]  = isF && (rxWord != FILL_WORD);
    mask[4]  = ptrSeen && (wordPtr != 7'(prevPtr + 7'd1));
    wordErr  = |mask;
    frameErr = frameBad | wordErr;
  end

  // Frame-lock next state, evaluated on the slot-127 word
  always_comb begin
    state_nx    = state;
    goodNx      = goodCnt;
    badNx       = badCnt;
    enterSearch = 1'b0;
    if (wordValid && lastSlot) begin
      case (state)
        SEARCH: begin
          if (frameErr)                      goodNx = '0;
          else if (goodCnt + 4'd1 == LOCK_N) begin
            state_nx = LOCKED;
            goodNx   = '0;
            badNx    = '0;
          end else                           goodNx = goodCnt + 4'd1;
        end
        LOCKED: begin
          if (!frameErr)                     badNx = '0;
          else if (badCnt + 4'd1 == UNLOCK_N) begin
            state_nx    = SEARCH;
            enterSearch = 1'b1;
            goodNx      = '0;
            badNx       = '0;
          end else                           badNx = badCnt + 4'd1;
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  // Word-processing registers; stored counters resync to received payloads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      goodCnt   <= '0;
      badCnt    <= '0;
      seedA     <= 1'b0;
      seedB     <= 1'b0;
      seedC     <= 1'b0;
      ptrSeen   <= 1'b0;
      prevPtr   <= '0;
      prevBg0   <= 1'b0;
      frameBad  <= 1'b0;
      frameDone <= 1'b0;
      frameOk   <= 1'b0;
      errStrobe <= 1'b0;
      errMask   <= '0;
      valA      <= '0;
      valB      <= '0;
      valC      <= '0;
    end else begin
      frameDone <= 1'b0;
      frameOk   <= 1'b0;
      errStrobe <= 1'b0;
      errMask   <= '0;
      if (wordValid) begin
        errStrobe <= wordErr;
        errMask   <= mask;
        prevPtr   <= wordPtr;
        ptrSeen   <= 1'b1;
        if (isA) begin valA <= payAB; seedA <= 1'b1; end
        if (isB) begin valB <= payAB; seedB <= 1'b1; prevBg0 <= (grpNum == 5'd0); end
        if (isC) begin valC <= payC;  seedC <= 1'b1; end
        frameBad  <= lastSlot ? 1'b0 : frameErr;
        if (lastSlot) begin
          frameDone <= 1'b1;
          frameOk   <= !frameErr;
        end
        state   <= state_nx;
        goodCnt <= goodNx;
        badCnt  <= badNx;
        if (enterSearch) begin
          seedA   <= 1'b0;
          seedB   <= 1'b0;
          seedC   <= 1'b0;
          ptrSeen <= 1'b0;
        end
      end
    end
  end

  // Saturating error counter, counts only while locked; clear has priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      errCount <= '0;
    else if (clrCnt)
      errCount <= '0;
    else if (wordValid && wordErr && state == LOCKED && errCount != 16'hFFFF)
      errCount <= errCount + 16'd1;
  end

endmodule

// File: doc/m1_checker.md
# m1_checker

Receive-side verifier for the M1 telemetry word stream produced by the imitator's word filler. It consumes 12-bit words tagged with their frame slot pointer (0..127) and group number, and recovers the three embedded counters: slot 2, slot 34 and every slot ≡1 mod 4. It checks the counters and the constant filler slots for continuity and content, runs a frame-lock state machine, and reports per-word errors, per-frame status and a saturating error count. It sits after the frame deserializer in loopback/self-test builds.

## Interface
- LOCK_FRAMES, 2, consecutive good frames needed to enter LOCKED (1..15)
- UNLOCK_FRAMES, 4, consecutive bad frames needed to drop to SEARCH (1..15)
- FILL_WORD, 12'h002, required content of filler slots
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- wordValid  in  1  rxWord/wordPtr/grpNum valid this cycle
- wordPtr  in  7  slot index of rxWord within frame
- grpNum  in  5  group number of current frame
- rxWord  in  12  received data word
- clrCnt  in  1  synchronous clear of errCount
- locked  out  1  FSM in LOCKED
- frameDone  out  1  one-cycle pulse after the slot-127 word is processed
- frameOk  out  1  valid with frameDone: frame had no errors
- errStrobe  out  1  one-cycle pulse: processed word failed a check
- errMask  out  5  per-word error class {ptr, fill, C, B, A}, valid with errStrobe
- errCount  out  16  saturating count of erroneous words while LOCKED
- valA  out  10  last received slot-2 counter
- valB  out  10  last received slot-34 counter
- valC  out  8  last received mod-4 counter

## Operation
- Slot classes, decoded from wordPtr:
  - Slot 2 → A: payload rxWord[10:1]; rxWord[11], rxWord[0] must be 0.
  - Slot 34 → B: same format as A.
  - wordPtr[1:0]==2'b01 → C: payload rxWord[10:3]; rxWord[11] and rxWord[2:0] must be 0.
  - All other slots, including 0 → fill: rxWord must equal FILL_WORD.
- Format violation in A/B/C sets that class's error bit, same as a value mismatch.
- Expectations:
  - A: previous A + 1, mod 1024.
  - B: previous B + (previous B word's grpNum==0 ? 1 : 0), mod 1024.
  - C: previous C + 1, mod 256; continues across frame boundary (slot 125 → next frame slot 1).
- Seeding: each counter has a seeded flag, cleared at reset and on entry to SEARCH. The first observation of an unseeded counter loads it with no error.
- Resync: after every A/B/C word, the stored previous value takes the received payload, not the expectation. One corrupted word therefore gives at most two errors, never a cascade.
- ptr check: wordPtr must equal (previous wordPtr + 1) mod 128. The first valid word after reset or SEARCH entry is exempt. A gap sets errMask[4] and does not reseed counters.
- Frame status: a frame is bad if any word since the previous frameDone flagged an error.
- FSM states: SEARCH (reset state), LOCKED.
  - SEARCH: good-frame counter increments per good frame and clears on a bad frame; reaching LOCK_FRAMES → LOCKED.
  - LOCKED: bad-frame counter increments per bad frame and clears on a good frame; reaching UNLOCK_FRAMES → SEARCH, clearing seeded flags and both frame counters.
- errStrobe/errMask are reported in both states. errCount increments only in LOCKED and saturates at 16'hFFFF.
- clrCnt with an increment in the same cycle → errCount = 0; clear wins.

## Timing
- All outputs are registered: word in cycle n → errStrobe/errMask/valX updates in cycle n+1.
- Slot-127 word in cycle n → frameDone/frameOk in cycle n+1. A state change caused by that frame shows on `locked` in cycle n+1.
- wordValid low: no state change; strobes deasserted.
- Back-to-back valid words every cycle are supported, with no stall.
- Reset values: all outputs 0, FSM in SEARCH, all expectations 0 and unseeded.
- Reset asserted mid-frame aborts immediately. The next frame is checked from scratch, with the ptr check exempt for its first word.

## Test plan
- Clean stream from the filler model, 8 frames with grpNum 0..7, A starting at 10'h3FE → A wraps 3FF→000 with no error; locked rises with frameDone of frame 2; errCount stays 0.
- While LOCKED, corrupt one fill word to 12'h003 → errStrobe with errMask=5'b01000 exactly once; errCount=1; that frame's frameOk=0; locked stays 1.
- While LOCKED, inject C=8'h40 where 8'h3F is expected → errMask=5'b00100 on that word and on the next C word; 2 errors total.
- B sequence across grpNum 31,0,1 with values 5,5,6 → no error. Feed 5,5,5 instead → one B error on the grp-1 word.
- Skip slots 10..12 in 4 consecutive frames → errMask[4] each frame; locked falls at the 4th frameDone; errCount saturates when preloaded near 16'hFFFF.
- Assert clrCnt in the same cycle as an error increment → errCount=0. Assert reset mid-frame → all outputs 0 next cycle.
